// File: rtl/hm10_uart_tx.sv
// hm10_uart_tx -- 8N1 UART transmitter feeding the HM-10/HC-06 DI pin.
//
// Bytes are pushed into a small circular FIFO with a one-cycle strobe; the
// serial FSM drains it one frame at a time (start bit, 8 data bits LSB first,
// stop bit), each bit lasting CLKS_PER_BIT clocks.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   data_in     byte to queue, captured when send & ready
//   send        one-cycle push strobe
//   ready       FIFO not full
//   tx          registered serial line, idle high
//   busy        frame on the line or bytes still queued
//   overflow    sticky: a push arrived while the FIFO was full
//   fifo_count  current FIFO occupancy
module hm10_uart_tx #(
   parameter int CLKS_PER_BIT    = 5208,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 data_in,
   input  logic                       send,
   output logic                       ready,
   output logic                       tx,
   output logic                       busy,
   output logic                       overflow,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);
   localparam int PW = FIFO_DEPTH_LOG2;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [PW:0]   FULL     = (PW+1)'(1 << PW);
   localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [1 << PW];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          tx_nxt, push, pop, bit_done;

   assign ready    = (fifo_count != FULL);
   assign push     = send & ready;
   assign busy     = (state != IDLE) | (fifo_count != '0);
   assign bit_done = (baud_cnt == BAUD_MAX);

   // Storage needs no reset: only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         // Simultaneous push and pop leave the occupancy unchanged.
         if (push && !pop)      fifo_count <= fifo_count + (PW+1)'(1);
         else if (pop && !push) fifo_count <= fifo_count - (PW+1)'(1);
         if (send && !ready) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
         tx       <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      baud_nxt    = bit_done ? '0 : baud_cnt + CW'(1);
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      tx_nxt      = tx;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt = '0;
            tx_nxt   = 1'b1;
            // Pop and drop the line on the same edge: start bit begins
            // one clock after the byte reaches the FIFO head.
            if (fifo_count != '0) begin
               pop       = 1'b1;
               shift_nxt = mem[rd_ptr];
               tx_nxt    = 1'b0;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_done) begin
               tx_nxt      = shift[0];
               bit_idx_nxt = '0;
               state_nxt   = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == 3'd7) begin
                  tx_nxt    = 1'b1;
                  state_nxt = STOP;
               end else begin
                  shift_nxt   = {1'b0, shift[7:1]};
                  tx_nxt      = shift[1];
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_hm10_uart_tx.sv
// Bench for hm10_uart_tx: a fast instance (4 clks/bit) checked every cycle
// against a queue-based frame model, plus a default-rate instance measured
// for start-bit and frame length.
module tb_hm10_uart_tx;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset, send, send_s;
   logic [7:0] data_in, data_s;
   logic       ready, tx, busy, overflow;
   logic [2:0] fifo_count;
   logic       ready_s, tx_s, busy_s, overflow_s;
   logic [2:0] fifo_count_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   hm10_uart_tx #(.CLKS_PER_BIT(N), .FIFO_DEPTH_LOG2(2)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .send(send),
      .ready(ready), .tx(tx), .busy(busy), .overflow(overflow),
      .fifo_count(fifo_count)
   );

   hm10_uart_tx dut_slow (
      .clk(clk), .reset(reset), .data_in(data_s), .send(send_s),
      .ready(ready_s), .tx(tx_s), .busy(busy_s), .overflow(overflow_s),
      .fifo_count(fifo_count_s)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Line level during bit slot idx of a frame carrying b.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return b[idx-1];
   endfunction

   // Model: queue of pending bytes plus the start cycle of the current frame.
   // A frame occupies 10*N cycles; the next pop can happen one cycle later.
   logic [7:0] mq[$];
   logic [7:0] m_cur;
   bit         m_act, m_ovf, m_in;
   int         m_cyc, m_fst, m_nb;
   logic       m_tx;

   initial begin
      m_act = 0; m_ovf = 0; m_cyc = 0; m_fst = 0; m_cur = '0;
      forever begin
         @(posedge clk);
         if (reset) begin
            mq.delete();
            m_act = 0;
            m_ovf = 0;
         end else begin
            m_cyc++;
            m_nb = mq.size();
            if (m_nb > 0 && (!m_act || m_cyc >= m_fst + 10*N + 1)) begin
               m_cur = mq.pop_front();
               m_fst = m_cyc;
               m_act = 1;
            end
            if (send && m_nb < 4) mq.push_back(data_in);
            if (send && m_nb == 4) m_ovf = 1;
         end
         #1;
         m_in = m_act && (m_cyc - m_fst < 10*N);
         m_tx = m_in ? frame_bit(m_cur, (m_cyc - m_fst) / N) : 1'b1;
         chk("tx", tx, m_tx);
         chk("busy", busy, m_in || mq.size() != 0);
         chk("fifo_count", fifo_count, mq.size());
         chk("ready", ready, mq.size() < 4);
         chk("overflow", overflow, m_ovf);
      end
   end

   // Independent mid-bit decoder of the fast line.
   logic [7:0] rx_q[$];
   logic [7:0] rx_b;
   initial begin
      rx_b = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset && tx === 1'b0) begin
            repeat (N/2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (N) @(posedge clk);
               #1 rx_b[i] = tx;
            end
            repeat (N) @(posedge clk);
            #1 rx_q.push_back(rx_b);
         end
      end
   end

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      send    = 1'b1;
      data_in = b;
   endtask

   task automatic idle();
      @(negedge clk);
      send = 1'b0;
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busy && n < 2000);
      chk("idle_reached", busy, 1'b0);
   endtask

   task automatic check_rx(input string nm, input int n, input logic [63:0] exp);
      chk({nm, "_count"}, rx_q.size(), n);
      for (int i = 0; i < n; i++)
         chk(nm, (i < rx_q.size()) ? 64'(rx_q[i]) : 64'hFFFF, 64'(exp[8*i +: 8]));
      rx_q.delete();
   endtask

   logic [63:0] wv, bv, exp_w, exp_b;
   logic [9:0]  frame10, fb;
   int          k, lowc, n;
   bit          hi;

   initial begin
      reset = 1'b1; send = 1'b0; send_s = 1'b0; data_in = '0; data_s = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_cnt", fifo_count, 3'd0);
      chk("rst_ready", ready, 1'b1);
      reset = 1'b0;

      // 1: single byte 0x31; frame = start 0, 1000_1100 LSB first, stop 1
      frame10 = 10'b1_0011_0001_0;
      push(8'h31);
      @(posedge clk); #1;
      chk("t1_cnt_after_push", fifo_count, 3'd1);
      idle();
      wv = '0; bv = '0; exp_w = '0; exp_b = '0;
      for (int i = 0; i < 44; i++) begin
         @(posedge clk); #1;
         wv[i] = tx;
         bv[i] = busy;
         exp_w[i] = (i < 40) ? frame10[i/4] : 1'b1;
         exp_b[i] = (i < 40);
      end
      chk("t1_wave", wv, exp_w);
      chk("t1_busy", bv, exp_b);
      chk("t1_cnt_end", fifo_count, 3'd0);
      check_rx("t1_rx", 1, 64'h31);

      // 2: four back-to-back bytes
      push(8'hA5);
      @(posedge clk); #1;
      chk("t2_cnt0", fifo_count, 3'd1);
      push(8'h5A);
      @(posedge clk); #1;
      chk("t2_cnt_pushpop", fifo_count, 3'd1);
      push(8'hFF);
      push(8'h00);
      @(posedge clk); #1;
      chk("t2_cnt_peak", fifo_count, 3'd3);
      chk("t2_ready", ready, 1'b1);
      idle();
      wait_idle();
      chk("t2_ovf", overflow, 1'b0);
      check_rx("t2_rx", 4, 64'h00_FF_5A_A5);

      // 3: six bytes, sixth dropped
      for (int i = 1; i <= 6; i++) push(8'(i));
      @(posedge clk); #1;
      chk("t3_ovf", overflow, 1'b1);
      chk("t3_ready", ready, 1'b0);
      chk("t3_cnt", fifo_count, 3'd4);
      idle();
      wait_idle();
      chk("t3_ovf_sticky", overflow, 1'b1);
      check_rx("t3_rx", 5, 64'h05_04_03_02_01);

      // 4: push held across the pop edge; only the push right after the pop lands (0x86)
      rst_pulse();
      chk("t4_ovf_clr", overflow, 1'b0);
      for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
      for (int i = 0; i < 45; i++) push(8'h60 + 8'(i));
      idle();
      wait_idle();
      chk("t4_ovf", overflow, 1'b1);
      check_rx("t4_rx", 6, 64'h86_15_14_13_12_11);

      // 5: reset mid-DATA with two bytes queued
      rst_pulse();
      push(8'h55);
      push(8'h01);
      push(8'h02);
      idle();
      repeat (12) @(negedge clk);
      chk("t5_cnt_before", fifo_count, 3'd2);
      reset = 1'b1;
      #1;
      chk("t5_tx", tx, 1'b1);
      chk("t5_cnt", fifo_count, 3'd0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_ovf", overflow, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk("t5_tx_after", tx, 1'b1);
      chk("t5_busy_after", busy, 1'b0);
      rx_q.delete();

      // 6: default rate, byte 0x41
      @(negedge clk);
      send_s = 1'b1;
      data_s = 8'h41;
      @(negedge clk);
      send_s = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (tx_s && n < 20);
      chk("t6_start_seen", tx_s, 1'b0);
      k = 0; lowc = 0; hi = 0; fb = '1;
      while (busy_s && k < 60000) begin
         if (!tx_s && !hi) lowc++;
         else hi = 1;
         if (k < 52080 && (k % 5208) == 2604) fb[k/5208] = tx_s;
         @(posedge clk); #1;
         k++;
      end
      chk("t6_start_len", lowc, 5208);
      chk("t6_frame_len", k, 52080);
      chk("t6_bits", fb, {1'b1, 8'h41, 1'b0});
      chk("t6_cnt", fifo_count_s, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
